dram_pattern_checker: RTL and testbench
=======================================

# dram_pattern_checker

Self-contained DDR3 traffic generator and checker that sits on the user side of the MIG7-style DRAM controller, in place of the ORAM simulator, for bring-up and soak testing. It writes a parametrised region with a selectable data pattern, reads it back, and compares every returned beat against a regenerated expected value. It reports error counts, the first failing index, and sticky error flags, and can loop indefinitely with a rotating seed.

## Interface
Parameters:
- DDRCWidth, 3, command width; write = 3'b000, read = 3'b001
- DDRAWidth, 27, DRAM address width
- DDRDWidth, 512, data beat width; must be a multiple of 32
- DDRMWidth, DDRDWidth/8, write mask width
- NumBeats, 1024, beats per pass (≥1)
- AddrStep, 8, address increment per beat
- BaseAddress, 0, first address of region

Ports:
- Clock, in, 1, single clock
- Reset, in, 1, asynchronous, active-high
- Start, in, 1, one-cycle start pulse; ignored while Busy
- Loop, in, 1, sampled at end of each pass; 1 = run another pass
- Mode, in, 2, pattern select; sampled at Start
- Seed, in, 32, initial seed; sampled at Start
- DRAMCommand, out, DDRCWidth, command
- DRAMAddress, out, DDRAWidth, address
- DRAMCommandValid / DRAMCommandReady, out/in, 1, command handshake
- DRAMWriteData, out, DDRDWidth, write beat
- DRAMWriteMask, out, DDRMWidth, always 0 (all bytes written)
- DRAMWriteDataValid / DRAMWriteDataReady, out/in, 1, write-data handshake
- DRAMReadData, in, DDRDWidth, read beat
- DRAMReadDataValid, in, 1, read beat valid; no backpressure
- Busy, out, 1, high outside Idle/Done
- Done, out, 1, high in Done
- PassCount, out, 32, completed passes, saturating
- ErrorCount, out, 32, mismatched beats, saturating
- FirstErrorIndex, out, 32, beat index of the first mismatch since Start
- Error_DataMismatch, out, 1, sticky, set on any mismatch
- Error_Spurious, out, 1, sticky, set by ReadDataValid outside Read or after NumBeats returns

All outputs reset to 0.

## Operation
- States are Idle, Write, Read, and Done.
- Start in Idle or Done:
  - clears counters, FirstErrorIndex, and sticky flags
  - latches Mode and Seed
  - moves to Write
- Write:
  - The command counter and data counter advance independently on their own handshakes.
  - Command i is at address BaseAddress + i·AddrStep, mod 2^DDRAWidth.
  - Data beat i is pattern(Seed, i).
  - Leave Write when both counters reach NumBeats.
- Read:
  - Issue NumBeats read commands.
  - A separate return counter r advances on each DRAMReadDataValid.
  - Each returned beat is compared to pattern(Seed, r).
- End of pass, when r reaches NumBeats:
  - PassCount increments.
  - If Loop = 1, Seed increments by 1 and the block re-enters Write.
  - Otherwise it enters Done.
- Pattern, per 32-bit lane k of beat i:
  - Mode 0: Seed + i·(DDRDWidth/32) + k
  - Mode 1: 0xAAAAAAAA if (i[0]^k[0]) else 0x55555555, XOR Seed
  - Mode 2: 1 << ((i+k) mod 32)
  - Mode 3: bitwise inverse of Mode 0
- All arithmetic is modulo 2^32.
- A mismatch is any bit difference in the beat.
  - ErrorCount increments by 1 per mismatched beat.
  - FirstErrorIndex is written only while ErrorCount == 0.
- Reset mid-operation: return immediately to Idle. No further valid is issued, and outstanding DRAM reads are not drained.

## Timing
- Start at cycle t: Busy = 1 and DRAMCommandValid = 1 at t+1.
- Valid rule: once asserted, a valid stays high with stable payload until its ready.
- Throughput:
  - Back-to-back command with ready high: 1 command per cycle.
  - Write data is likewise 1 beat per cycle.
- Read return:
  - Beat returned at cycle t updates ErrorCount and Error_DataMismatch at t+1.
  - The final beat's Done (or re-entry to Write) takes effect at t+1.
- Loop pass boundary: the first write command of the next pass is valid at t+2.
- If a read return and a saturating counter both hit their limit, the counter holds its maximum.

## Structure
- Shared header dram_tester.vh holds:
  - command encodings
  - Mode encodings
  - state encodings
- Sub-module dram_pattern_gen, purely combinational: (Mode, Seed, index) → DDRDWidth beat.
  - It is instantiated twice: one copy for write data, one for expected read data.
- The top-level FSM and counters live in dram_pattern_checker.

## Test plan
- NumBeats=16, Mode 0, Seed=0, ideal DRAM model → 16 writes then 16 reads; Done; ErrorCount=0; PassCount=1.
- Same, with the model flipping one bit of return beat 5 → ErrorCount=1, FirstErrorIndex=5, Error_DataMismatch=1.
- Random deassertion of CommandReady and WriteDataReady (50%) → payloads held stable while valid; no lost or duplicated beats; ErrorCount=0.
- Loop=1 for 3 passes then Loop=0, Mode 2 → PassCount=3, Seed advances each pass, Done asserted.
- Inject ReadDataValid while in Write → Error_Spurious=1; ErrorCount unchanged.
- Assert Reset during Read with 8 reads outstanding → all outputs 0 next cycle; later Start runs clean.

Source files
------------

// File: rtl/dram_pattern_checker_pkg.sv
// Command/mode/state encodings and the per-lane data pattern shared by the
// DRAM pattern checker and its pattern generators.
package dram_pattern_checker_pkg;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  localparam logic [1:0] MODE_COUNT     = 2'd0;
  localparam logic [1:0] MODE_CHECKER   = 2'd1;
  localparam logic [1:0] MODE_WALK      = 2'd2;
  localparam logic [1:0] MODE_INV_COUNT = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ, ST_DONE} state_e;

  // One 32-bit lane of beat 'index'; 'lanes' is the number of lanes per beat.
  function automatic logic [31:0] pattern_lane(
    input logic [1:0]  mode,
    input logic [31:0] seed,
    input logic [31:0] index,
    input logic [31:0] lane,
    input logic [31:0] lanes
  );
    logic [31:0] count;
    logic [4:0]  walk;
    count = seed + index * lanes + lane;
    walk  = index[4:0] + lane[4:0];
    case (mode)
      MODE_COUNT:     pattern_lane = count;
      MODE_CHECKER:   pattern_lane = ((index[0] ^ lane[0]) ? 32'hAAAA_AAAA : 32'h5555_5555) ^ seed;
      MODE_WALK:      pattern_lane = 32'd1 << walk;
      MODE_INV_COUNT: pattern_lane = ~count;
      default:        pattern_lane = count;
    endcase
  endfunction

endpackage

// File: rtl/dram_pattern_gen.sv
// Purely combinational beat generator: (mode, seed, beat index) -> full data beat.
module dram_pattern_gen
  import dram_pattern_checker_pkg::*;
#(
  parameter int DDRDWidth = 512
) (
  input  logic [1:0]           i_mode,
  input  logic [31:0]          i_seed,
  input  logic [31:0]          i_index,
  output logic [DDRDWidth-1:0] o_beat
);

  localparam int Lanes = DDRDWidth / 32;

  always_comb begin
    // NOTE: default first so every path assigns o_beat and no latch is inferred.
    o_beat = '0;
    for (int k = 0; k < Lanes; k++) begin
      o_beat[k*32 +: 32] = pattern_lane(i_mode, i_seed, i_index, 32'(k), 32'(Lanes));
    end
  end

endmodule

// File: rtl/dram_pattern_checker.sv
// DDR3 traffic generator/checker: writes a patterned region, reads it back,
// and counts mismatching beats; can loop with an incrementing seed.
module dram_pattern_checker
  import dram_pattern_checker_pkg::*;
#(
  parameter int DDRCWidth   = 3,
  parameter int DDRAWidth   = 27,
  parameter int DDRDWidth   = 512,
  parameter int DDRMWidth   = DDRDWidth / 8,
  parameter int NumBeats    = 1024,
  parameter int AddrStep    = 8,
  parameter int BaseAddress = 0
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic                 Loop,
  input  logic [1:0]           Mode,
  input  logic [31:0]          Seed,
  output logic [DDRCWidth-1:0] DRAMCommand,
  output logic [DDRAWidth-1:0] DRAMAddress,
  output logic                 DRAMCommandValid,
  input  logic                 DRAMCommandReady,
  output logic [DDRDWidth-1:0] DRAMWriteData,
  output logic [DDRMWidth-1:0] DRAMWriteMask,
  output logic                 DRAMWriteDataValid,
  input  logic                 DRAMWriteDataReady,
  input  logic [DDRDWidth-1:0] DRAMReadData,
  input  logic                 DRAMReadDataValid,
  output logic                 Busy,
  output logic                 Done,
  output logic [31:0]          PassCount,
  output logic [31:0]          ErrorCount,
  output logic [31:0]          FirstErrorIndex,
  output logic                 Error_DataMismatch,
  output logic                 Error_Spurious
);

  localparam logic [31:0]          BeatsTotal = 32'(NumBeats);
  localparam logic [31:0]          LastIdx    = 32'(NumBeats - 1);
  localparam logic [DDRAWidth-1:0] BaseAddr   = DDRAWidth'(BaseAddress);
  localparam logic [DDRAWidth-1:0] StepAddr   = DDRAWidth'(AddrStep);

  state_e               r_state;
  logic [1:0]           r_mode;
  logic [31:0]          r_seed;
  logic [31:0]          r_cmd_idx;
  logic [31:0]          r_wd_idx;
  logic [31:0]          r_ret_idx;
  logic [DDRAWidth-1:0] r_addr;
  logic                 r_cmd_valid;
  logic                 r_wd_valid;
  logic                 r_launch;
  logic [31:0]          r_pass;
  logic [31:0]          r_err;
  logic [31:0]          r_first;
  logic                 r_mismatch;
  logic                 r_spurious;

  logic [DDRDWidth-1:0] w_wr_beat;
  logic [DDRDWidth-1:0] w_exp_beat;
  logic                 w_cmd_fire;
  logic                 w_wd_fire;
  logic                 w_cmd_fin;
  logic                 w_wd_fin;
  logic                 w_ret_fire;
  logic                 w_ret_last;
  logic                 w_mismatch;
  logic                 w_spurious;

  dram_pattern_gen #(.DDRDWidth(DDRDWidth)) u_gen_wr (
    .i_mode  (r_mode),
    .i_seed  (r_seed),
    .i_index (r_wd_idx),
    .o_beat  (w_wr_beat)
  );

  dram_pattern_gen #(.DDRDWidth(DDRDWidth)) u_gen_rd (
    .i_mode  (r_mode),
    .i_seed  (r_seed),
    .i_index (r_ret_idx),
    .o_beat  (w_exp_beat)
  );

  assign w_cmd_fire = r_cmd_valid && DRAMCommandReady;
  assign w_wd_fire  = r_wd_valid && DRAMWriteDataReady;
  assign w_cmd_fin  = (r_cmd_idx == BeatsTotal) || (w_cmd_fire && r_cmd_idx == LastIdx);
  assign w_wd_fin   = (r_wd_idx == BeatsTotal) || (w_wd_fire && r_wd_idx == LastIdx);
  assign w_ret_fire = DRAMReadDataValid && (r_state == ST_READ) && (r_ret_idx != BeatsTotal);
  assign w_ret_last = w_ret_fire && (r_ret_idx == LastIdx);
  assign w_mismatch = w_ret_fire && (DRAMReadData != w_exp_beat);
  assign w_spurious = DRAMReadDataValid && !w_ret_fire;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state     <= ST_IDLE;
      r_mode      <= '0;
      r_seed      <= '0;
      r_cmd_idx   <= '0;
      r_wd_idx    <= '0;
      r_ret_idx   <= '0;
      r_addr      <= '0;
      r_cmd_valid <= 1'b0;
      r_wd_valid  <= 1'b0;
      r_launch    <= 1'b0;
      r_pass      <= '0;
      r_err       <= '0;
      r_first     <= '0;
      r_mismatch  <= 1'b0;
      r_spurious  <= 1'b0;
    end else begin
      // NOTE: non-blocking updates; later assignments in this block override earlier ones.
      if (w_spurious) r_spurious <= 1'b1;
      if (w_mismatch) begin
        if (r_err == '0) r_first <= r_ret_idx;
        if (r_err != '1) r_err <= r_err + 32'd1;
        r_mismatch <= 1'b1;
      end
      if (w_ret_fire) r_ret_idx <= r_ret_idx + 32'd1;
      if (w_cmd_fire) begin
        r_cmd_idx <= r_cmd_idx + 32'd1;
        r_addr    <= r_addr + StepAddr;
        if (r_cmd_idx == LastIdx) r_cmd_valid <= 1'b0;
      end
      if (w_wd_fire) begin
        r_wd_idx <= r_wd_idx + 32'd1;
        if (r_wd_idx == LastIdx) r_wd_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (Start) begin
            r_state     <= ST_WRITE;
            r_mode      <= Mode;
            r_seed      <= Seed;
            r_cmd_idx   <= '0;
            r_wd_idx    <= '0;
            r_ret_idx   <= '0;
            r_addr      <= BaseAddr;
            r_cmd_valid <= 1'b1;
            r_wd_valid  <= 1'b1;
            r_pass      <= '0;
            r_err       <= '0;
            r_first     <= '0;
            r_mismatch  <= 1'b0;
            r_spurious  <= 1'b0;
          end
        end
        ST_WRITE: begin
          // A looped pass spends one cycle in Write before its first valid.
          if (r_launch) begin
            r_launch    <= 1'b0;
            r_cmd_valid <= 1'b1;
            r_wd_valid  <= 1'b1;
          end else if (w_cmd_fin && w_wd_fin) begin
            r_state     <= ST_READ;
            r_cmd_idx   <= '0;
            r_addr      <= BaseAddr;
            r_cmd_valid <= 1'b1;
          end
        end
        ST_READ: begin
          if (w_ret_last) begin
            if (r_pass != '1) r_pass <= r_pass + 32'd1;
            r_cmd_valid <= 1'b0;
            if (Loop) begin
              r_state   <= ST_WRITE;
              r_launch  <= 1'b1;
              r_seed    <= r_seed + 32'd1;
              r_cmd_idx <= '0;
              r_wd_idx  <= '0;
              r_ret_idx <= '0;
              r_addr    <= BaseAddr;
            end else begin
              r_state <= ST_DONE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign DRAMCommand        = (r_state == ST_READ) ? DDRCWidth'(CMD_READ) : DDRCWidth'(CMD_WRITE);
  assign DRAMAddress        = r_addr;
  assign DRAMCommandValid   = r_cmd_valid;
  assign DRAMWriteData      = r_wd_valid ? w_wr_beat : '0;
  assign DRAMWriteMask      = '0;
  assign DRAMWriteDataValid = r_wd_valid;
  assign Busy               = (r_state == ST_WRITE) || (r_state == ST_READ);
  assign Done               = (r_state == ST_DONE);
  assign PassCount          = r_pass;
  assign ErrorCount         = r_err;
  assign FirstErrorIndex    = r_first;
  assign Error_DataMismatch = r_mismatch;
  assign Error_Spurious     = r_spurious;

endmodule

// File: tb/tb_dram_pattern_checker.sv
// Directed bench for dram_pattern_checker with a small DRAM model (64-bit beats, 16 beats/pass).
module tb_dram_pattern_checker;

  localparam int CW   = 3;
  localparam int AW   = 27;
  localparam int DW   = 64;
  localparam int MW   = DW / 8;
  localparam int NB   = 16;
  localparam int STEP = 8;
  localparam int BASE = 'h40;
  localparam int LAT  = 12;

  logic          Clock;
  logic          Reset;
  logic          Start;
  logic          Loop;
  logic [1:0]    Mode;
  logic [31:0]   Seed;
  logic [CW-1:0] DRAMCommand;
  logic [AW-1:0] DRAMAddress;
  logic          DRAMCommandValid;
  logic          DRAMCommandReady;
  logic [DW-1:0] DRAMWriteData;
  logic [MW-1:0] DRAMWriteMask;
  logic          DRAMWriteDataValid;
  logic          DRAMWriteDataReady;
  logic [DW-1:0] DRAMReadData;
  logic          DRAMReadDataValid;
  logic          Busy;
  logic          Done;
  logic [31:0]   PassCount;
  logic [31:0]   ErrorCount;
  logic [31:0]   FirstErrorIndex;
  logic          Error_DataMismatch;
  logic          Error_Spurious;

  dram_pattern_checker #(
    .DDRCWidth(CW), .DDRAWidth(AW), .DDRDWidth(DW), .DDRMWidth(MW),
    .NumBeats(NB), .AddrStep(STEP), .BaseAddress(BASE)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Loop(Loop), .Mode(Mode), .Seed(Seed),
    .DRAMCommand(DRAMCommand), .DRAMAddress(DRAMAddress),
    .DRAMCommandValid(DRAMCommandValid), .DRAMCommandReady(DRAMCommandReady),
    .DRAMWriteData(DRAMWriteData), .DRAMWriteMask(DRAMWriteMask),
    .DRAMWriteDataValid(DRAMWriteDataValid), .DRAMWriteDataReady(DRAMWriteDataReady),
    .DRAMReadData(DRAMReadData), .DRAMReadDataValid(DRAMReadDataValid),
    .Busy(Busy), .Done(Done), .PassCount(PassCount), .ErrorCount(ErrorCount),
    .FirstErrorIndex(FirstErrorIndex), .Error_DataMismatch(Error_DataMismatch),
    .Error_Spurious(Error_Spurious)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // DRAM model state
  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } rd_t;

  logic [AW-1:0] wcmd_q[$];
  logic [DW-1:0] wdata_q[$];
  rd_t           rd_q[$];
  logic [DW-1:0] mem[int];
  logic [DW-1:0] wbeat[NB];
  int            n_wcmd, n_wdata, n_rcmd, n_ret;
  int            cyc;
  bit            rand_ready;
  bit            inject_spur;
  logic [NB-1:0] flip_mask;
  bit            cmd_hold, wd_hold;
  logic [CW+AW-1:0] cmd_prev;
  logic [DW-1:0] wd_prev;

  function automatic logic [AW-1:0] exp_addr(input int n);
    return AW'(BASE + (n % NB) * STEP);
  endfunction

  function automatic int beat_idx(input logic [AW-1:0] a);
    return (int'(a) - BASE) / STEP;
  endfunction

  function automatic logic [12:0] outs_vec();
    return {Busy, Done, DRAMCommandValid, DRAMWriteDataValid, Error_DataMismatch, Error_Spurious,
            |DRAMCommand, |DRAMAddress, |DRAMWriteData, |DRAMWriteMask,
            |PassCount, |ErrorCount, |FirstErrorIndex};
  endfunction

  // Inputs change on the falling edge; the DUT samples them on the next rising edge.
  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    rd_t           r;
    int            bi;
    DRAMCommandReady   = 1'b1;
    DRAMWriteDataReady = 1'b1;
    DRAMReadDataValid  = 1'b0;
    DRAMReadData       = '0;
    cyc = 0;
    cmd_hold = 0;
    wd_hold  = 0;
    forever begin
      @(negedge Clock);
      cyc++;
      if (Reset) begin
        cmd_hold = 0;
        wd_hold  = 0;
        DRAMReadDataValid = 1'b0;
        continue;
      end
      if (cmd_hold) check("cmd_hold", {DRAMCommandValid, DRAMCommand, DRAMAddress}, {1'b1, cmd_prev});
      if (wd_hold) begin
        check("wd_hold_valid", DRAMWriteDataValid, 1);
        check("wd_hold_data", DRAMWriteData, wd_prev);
      end
      DRAMCommandReady   = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      DRAMWriteDataReady = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      cmd_hold = DRAMCommandValid && !DRAMCommandReady;
      cmd_prev = {DRAMCommand, DRAMAddress};
      wd_hold  = DRAMWriteDataValid && !DRAMWriteDataReady;
      wd_prev  = DRAMWriteData;
      if (DRAMCommandValid && DRAMCommandReady) begin
        if (DRAMCommand == 3'b000) begin
          check("wr_addr", DRAMAddress, exp_addr(n_wcmd));
          wcmd_q.push_back(DRAMAddress);
          n_wcmd++;
        end else begin
          check("rd_addr", DRAMAddress, exp_addr(n_rcmd));
          rd_q.push_back('{DRAMAddress, cyc + LAT});
          n_rcmd++;
        end
      end
      if (DRAMWriteDataValid && DRAMWriteDataReady) begin
        wdata_q.push_back(DRAMWriteData);
        n_wdata++;
      end
      while (wcmd_q.size() > 0 && wdata_q.size() > 0) begin
        a = wcmd_q.pop_front();
        d = wdata_q.pop_front();
        mem[int'(a)] = d;
        bi = beat_idx(a);
        if (bi >= 0 && bi < NB) wbeat[bi] = d;
      end
      if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
        r  = rd_q.pop_front();
        d  = mem.exists(int'(r.addr)) ? mem[int'(r.addr)] : '0;
        bi = beat_idx(r.addr);
        if (bi >= 0 && bi < NB && flip_mask[bi]) d[17] = ~d[17];
        DRAMReadData      = d;
        DRAMReadDataValid = 1'b1;
        n_ret++;
      end else if (inject_spur) begin
        DRAMReadData      = '1;
        DRAMReadDataValid = 1'b1;
        inject_spur       = 0;
      end else begin
        DRAMReadDataValid = 1'b0;
      end
    end
  end

  task automatic start_run(input logic [1:0] m, input logic [31:0] s, input logic lp,
                           input logic [DW-1:0] beat0);
    @(negedge Clock);
    Mode  = m;
    Seed  = s;
    Loop  = lp;
    Start = 1'b1;
    n_wcmd = 0; n_wdata = 0; n_rcmd = 0; n_ret = 0;
    @(negedge Clock);
    Start = 1'b0;
    check("start_valids", {Busy, DRAMCommandValid, DRAMWriteDataValid}, 3'b111);
    check("start_cmd", {DRAMCommand, DRAMAddress}, {3'b000, AW'(BASE)});
    check("start_beat0", DRAMWriteData, beat0);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!Done && n < 3000) begin
      @(negedge Clock);
      n++;
    end
    check({tag, "_done"}, {Done, Busy}, 2'b10);
  endtask

  task automatic wait_pass(input int target);
    int n = 0;
    while (PassCount < 32'(target) && n < 3000) begin
      @(negedge Clock);
      n++;
    end
    check("pass_reached", PassCount, 32'(target));
  endtask

  function automatic logic [31:0] counts();
    return {8'(n_wcmd), 8'(n_wdata), 8'(n_rcmd), 8'(n_ret)};
  endfunction

  initial begin
    Reset = 1'b1; Start = 1'b0; Loop = 1'b0; Mode = '0; Seed = '0;
    rand_ready = 0; inject_spur = 0; flip_mask = '0;
    repeat (3) @(negedge Clock);
    check("reset_outputs", outs_vec(), 13'd0);
    Reset = 1'b0;
    @(negedge Clock);
    check("idle_outputs", outs_vec(), 13'd0);

    // Mode 0, seed 0: lane k of beat i is 2i+k
    start_run(2'd0, 32'd0, 1'b0, {32'd1, 32'd0});
    wait_done("t1");
    check("t1_err", ErrorCount, 0);
    check("t1_pass", PassCount, 1);
    check("t1_flags", {Error_DataMismatch, Error_Spurious}, 2'b00);
    check("t1_counts", counts(), 32'h1010_1010);
    check("t1_beat3", wbeat[3], {32'd7, 32'd6});
    check("t1_beat15", wbeat[15], {32'd31, 32'd30});

    // Corrupt return beats 5 and 9: two errors, first index stays 5
    flip_mask = 16'h0220;
    start_run(2'd0, 32'd0, 1'b0, {32'd1, 32'd0});
    wait_done("t2");
    flip_mask = '0;
    check("t2_err", ErrorCount, 2);
    check("t2_first", FirstErrorIndex, 5);
    check("t2_flags", {Error_DataMismatch, Error_Spurious}, 2'b10);
    check("t2_pass", PassCount, 1);

    // Mode 1 under random backpressure
    rand_ready = 1;
    start_run(2'd1, 32'h1234_5678, 1'b0, {32'hB89E_FCD2, 32'h4761_032D});
    wait_done("t3");
    rand_ready = 0;
    check("t3_err", ErrorCount, 0);
    check("t3_counts", counts(), 32'h1010_1010);
    check("t3_beat1", wbeat[1], {32'h4761_032D, 32'hB89E_FCD2});
    check("t3_beat6", wbeat[6], {32'hB89E_FCD2, 32'h4761_032D});

    // Mode 2, three looped passes; check the pass-boundary gap
    start_run(2'd2, 32'd5, 1'b1, {32'h2, 32'h1});
    wait_pass(1);
    check("loop_gap", {Busy, DRAMCommandValid, DRAMWriteDataValid}, 3'b100);
    @(negedge Clock);
    check("loop_relaunch", {DRAMCommandValid, DRAMCommand, DRAMAddress}, {1'b1, 3'b000, AW'(BASE)});
    wait_pass(2);
    Loop = 1'b0;
    wait_done("t4");
    check("t4_pass", PassCount, 3);
    check("t4_err", ErrorCount, 0);
    check("t4_beat3", wbeat[3], {32'h10, 32'h8});
    check("t4_beat15", wbeat[15], {32'h0001_0000, 32'h0000_8000});

    // Mode 3, seed wraps 0xFFFFFFFF -> 0 on the second pass
    start_run(2'd3, 32'hFFFF_FFFF, 1'b1, {32'hFFFF_FFFF, 32'h0});
    wait_pass(1);
    Loop = 1'b0;
    wait_done("t5");
    check("t5_pass", PassCount, 2);
    check("t5_err", ErrorCount, 0);
    check("t5_beat2", wbeat[2], {32'hFFFF_FFFA, 32'hFFFF_FFFB});

    // Read return injected during Write
    start_run(2'd0, 32'h1000, 1'b0, {32'h1001, 32'h1000});
    inject_spur = 1;
    wait_done("t6");
    check("t6_flags", {Error_DataMismatch, Error_Spurious}, 2'b01);
    check("t6_err", ErrorCount, 0);
    check("t6_pass", PassCount, 1);

    // Reset with reads outstanding, then a clean run
    start_run(2'd0, 32'h77, 1'b0, {32'h78, 32'h77});
    begin
      int n = 0;
      while ((n_rcmd - n_ret) < 8 && n < 500) begin
        @(negedge Clock);
        n++;
      end
    end
    check("rst_outstanding", {Busy, 1'((n_rcmd - n_ret) >= 8)}, 2'b11);
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    check("rst_mid_outputs", outs_vec(), 13'd0);
    wcmd_q.delete(); wdata_q.delete(); rd_q.delete();
    @(negedge Clock);
    Reset = 1'b0;
    start_run(2'd0, 32'd0, 1'b0, {32'd1, 32'd0});
    wait_done("t7");
    check("t7_err", ErrorCount, 0);
    check("t7_pass", PassCount, 1);
    check("t7_flags", {Error_DataMismatch, Error_Spurious}, 2'b00);
    check("t7_counts", counts(), 32'h1010_1010);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
